// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   port (IF) and the load/store data port (D) of the multicycle CPU.
//   Contention is resolved round-robin. Each granted access becomes one
//   req/ack transaction on the memory side. Completion is reported to the
//   requester with a one-cycle done pulse and registered read data.
//   An access that never receives mem_ack is aborted with err after
//   MAX_WAIT busy cycles.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous reset, active low
//   if_req     fetch request (level, held until if_done)
//   if_addr    fetch address
//   if_rdata   fetched word (registered)
//   if_done    one-cycle fetch completion pulse
//   d_req      data request (level, held until d_done)
//   d_we       1 = store, 0 = load
//   d_addr     data address
//   d_wdata    store data
//   d_rdata    load data (registered)
//   d_done     one-cycle data completion pulse
//   mem_req    memory request (registered)
//   mem_we     memory write enable (registered)
//   mem_addr   memory address (registered)
//   mem_wdata  memory write data (registered)
//   mem_rdata  memory read data, valid with mem_ack
//   mem_ack    memory completion, only looked at while mem_req=1
//   err        one-cycle pulse together with done when the access timed out
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} stateT;

  // Counter value of the last busy cycle allowed before abort.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  stateT      stateReg, stateNext;
  logic [7:0] waitCnt;
  logic       lastGrantD;   // 1 = data port won the most recent grant
  logic       grantI, grantD;
  logic       ackSeen, timeout;

  // Next-state and grant decisions.
  always_comb begin
    stateNext = stateReg;
    grantI    = 1'b0;
    grantD    = 1'b0;
    ackSeen   = 1'b0;
    timeout   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (if_req && d_req) begin
          // Round robin: the port that did not win last time goes first.
          if (lastGrantD) grantI = 1'b1;
          else            grantD = 1'b1;
        end else if (if_req) begin
          grantI = 1'b1;
        end else if (d_req) begin
          grantD = 1'b1;
        end
        if (grantI)      stateNext = BUSY_I;
        else if (grantD) stateNext = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        // An ack in the final allowed cycle takes priority over the abort.
        if (mem_ack) begin
          ackSeen   = 1'b1;
          stateNext = RESP;
        end else if (waitCnt == LAST_WAIT) begin
          timeout   = 1'b1;
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  // Memory-side request registers and requester-side responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      waitCnt    <= '0;
      lastGrantD <= 1'b0;
    end else begin
      // Done and err are pulses: they only live for the RESP cycle.
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;

      if (grantI || grantD) begin
        mem_req    <= 1'b1;
        mem_we     <= grantD & d_we;
        mem_addr   <= grantD ? d_addr : if_addr;
        mem_wdata  <= grantD ? d_wdata : '0;
        lastGrantD <= grantD;
        waitCnt    <= '0;
      end

      if (ackSeen) begin
        mem_req <= 1'b0;
        if (stateReg == BUSY_I) begin
          if_rdata <= mem_rdata;
          if_done  <= 1'b1;
        end else begin
          // A store keeps the previous load result visible.
          if (!mem_we) d_rdata <= mem_rdata;
          d_done <= 1'b1;
        end
      end else if (timeout) begin
        mem_req <= 1'b0;
        err     <= 1'b1;
        if (stateReg == BUSY_I) begin
          if_rdata <= '0;
          if_done  <= 1'b1;
        end else begin
          d_rdata <= '0;
          d_done  <= 1'b1;
        end
      end else if (stateReg == BUSY_I || stateReg == BUSY_D) begin
        waitCnt <= waitCnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq, dReq, dWe;
  logic [31:0] ifAddr, dAddr, dWdata;
  logic [31:0] ifRdata, dRdata;
  logic        ifDone, dDone;
  logic        memReq, memWe, memAck;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        errOut;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (ifReq),
    .if_addr   (ifAddr),
    .if_rdata  (ifRdata),
    .if_done   (ifDone),
    .d_req     (dReq),
    .d_we      (dWe),
    .d_addr    (dAddr),
    .d_wdata   (dWdata),
    .d_rdata   (dRdata),
    .d_done    (dDone),
    .mem_req   (memReq),
    .mem_we    (memWe),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata),
    .mem_ack   (memAck),
    .err       (errOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        errBit;
    int          gap;      // expected cycles since previous done, 0 = unchecked
    int          busyLen;  // expected mem_req high cycles, 0 = unchecked
  } expT;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grantT;

  expT   ifQ[$];
  expT   dQ[$];
  grantT grantQ[$];
  int    orderQ[$];      // expected completion order, 0 = IF, 1 = D

  int errors = 0;
  int checks = 0;

  int          ackCycle = 1;  // busy cycle in which memory acks, 0 = never
  logic [31:0] rdataBase = '0;
  int          busyCnt = 0;
  int          lastBusyLen = 0;
  int          cycle = 0;
  int          lastDoneCycle = 0;
  grantT       curGrant;

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // Memory model followed by the completion monitor, in one process so the
  // busy-length bookkeeping is settled before the monitor reads it.
  initial begin
    memAck   = 1'b0;
    memRdata = '0;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (memReq) begin
        busyCnt++;
        if (busyCnt == 1) begin
          curGrant.addr  = memAddr;
          curGrant.we    = memWe;
          curGrant.wdata = memWdata;
          grantQ.push_back(curGrant);
        end else begin
          checkEq("mem_addr_held", memAddr, curGrant.addr);
          checkEq("mem_we_held", {31'd0, memWe}, {31'd0, curGrant.we});
        end
        memAck = (busyCnt == ackCycle);
        memRdata = memAck ? (rdataBase ^ memAddr) : $urandom;
      end else begin
        if (busyCnt != 0) lastBusyLen = busyCnt;
        busyCnt  = 0;
        // Ack while idle must be ignored.
        memAck   = ($urandom_range(0, 3) == 0);
        memRdata = $urandom;
      end

      if (errOut && !(ifDone || dDone)) checkEq("err_without_done", 32'd1, 32'd0);
      if (ifDone || dDone) begin
        int    port;
        expT   e;
        grantT g;
        port = dDone ? 1 : 0;
        checkEq("single_done", {31'd0, ifDone & dDone}, 32'd0);
        if (orderQ.size() > 0) checkEq("grant_order", port, orderQ.pop_front());
        if ((port == 1 && dQ.size() == 0) || (port == 0 && ifQ.size() == 0)) begin
          checkEq("spurious_done", port, 32'hFFFF_FFFF);
        end else begin
          e = (port == 1) ? dQ.pop_front() : ifQ.pop_front();
          $display("txn %s addr=%h we=%0d rdata=%h err=%0d cycle=%0d",
                   port ? "D " : "IF", e.addr, e.we, port ? dRdata : ifRdata, errOut, cycle);
          checkEq("rdata", port ? dRdata : ifRdata, e.rdata);
          checkEq("err", {31'd0, errOut}, {31'd0, e.errBit});
          if (grantQ.size() == 0) begin
            checkEq("missing_grant", 32'd0, 32'd1);
          end else begin
            g = grantQ.pop_front();
            checkEq("mem_addr", g.addr, e.addr);
            checkEq("mem_we", {31'd0, g.we}, {31'd0, e.we});
            if (e.we) checkEq("mem_wdata", g.wdata, e.wdata);
          end
          if (e.gap != 0) checkEq("done_gap", cycle - lastDoneCycle, e.gap);
          if (e.busyLen != 0) checkEq("busy_len", lastBusyLen, e.busyLen);
        end
        lastDoneCycle = cycle;
      end
    end
  end

  task automatic waitDone(input bit isD);
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (isD ? dDone : ifDone) break;
      n++;
      if (n > 200) begin
        checkEq(isD ? "d_done_timeout" : "if_done_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic reqI(input logic [31:0] addr, input logic [31:0] expRdata,
                      input logic expErr, input int gap, input int busyLen);
    expT e;
    e.addr = addr; e.we = 1'b0; e.wdata = '0; e.rdata = expRdata;
    e.errBit = expErr; e.gap = gap; e.busyLen = busyLen;
    ifQ.push_back(e);
    ifAddr = addr;
    ifReq  = 1'b1;
    waitDone(1'b0);
    ifReq = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic reqD(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] expRdata, input logic expErr,
                      input int gap, input int busyLen);
    expT e;
    e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = expRdata;
    e.errBit = expErr; e.gap = gap; e.busyLen = busyLen;
    dQ.push_back(e);
    dWe    = we;
    dAddr  = addr;
    dWdata = wdata;
    dReq   = 1'b1;
    waitDone(1'b1);
    dReq = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    ifReq  = 1'b0; ifAddr = '0;
    dReq   = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;

    repeat (3) @(posedge clk);
    #1;
    checkEq("rst_mem_req", {31'd0, memReq}, 32'd0);
    checkEq("rst_mem_addr", memAddr, 32'd0);
    checkEq("rst_done", {30'd0, ifDone, dDone}, 32'd0);
    checkEq("rst_err", {31'd0, errOut}, 32'd0);
    checkEq("rst_if_rdata", ifRdata, 32'd0);
    checkEq("rst_d_rdata", dRdata, 32'd0);
    reset = 1'b1;

    // Contention in the first cycle after reset: D first, then IF.
    ackCycle  = 1;
    rdataBase = 32'h1111_0000;
    orderQ.push_back(1);
    orderQ.push_back(0);
    fork
      reqI(32'h200, 32'h1111_0200, 1'b0, 3, 1);
      reqD(1'b0, 32'h300, 32'h0, 32'h1111_0300, 1'b0, 0, 1);
    join

    // Single fetch, ack in the second busy cycle.
    ackCycle  = 2;
    rdataBase = 32'h8C22_0044;
    reqI(32'h40, 32'h8C22_0004, 1'b0, 0, 2);

    // Both ports re-requesting back to back: D,I,D,I every 3 cycles.
    ackCycle  = 1;
    rdataBase = 32'h2222_0000;
    orderQ.push_back(1); orderQ.push_back(0);
    orderQ.push_back(1); orderQ.push_back(0);
    fork
      begin
        reqD(1'b0, 32'h410, 32'h0, 32'h2222_0410, 1'b0, 0, 1);
        reqD(1'b0, 32'h414, 32'h0, 32'h2222_0414, 1'b0, 3, 1);
      end
      begin
        reqI(32'h420, 32'h2222_0420, 1'b0, 3, 1);
        reqI(32'h424, 32'h2222_0424, 1'b0, 3, 1);
      end
    join

    // Preload d_rdata with a load, then a store must leave it alone.
    rdataBase = 32'h1234_5678 ^ 32'h104;
    reqD(1'b0, 32'h104, 32'h0, 32'h1234_5678, 1'b0, 0, 1);
    reqD(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0, 1);

    // Timeout after exactly 15 busy cycles, then an ack in the 15th cycle.
    ackCycle = 0;
    reqD(1'b0, 32'h500, 32'h0, 32'h0, 1'b1, 0, 15);
    ackCycle  = 15;
    rdataBase = 32'hCAFE_0000;
    reqD(1'b0, 32'h504, 32'h0, 32'hCAFE_0504, 1'b0, 0, 15);

    // Fetch timeout clears if_rdata.
    ackCycle = 0;
    reqI(32'h508, 32'h0, 1'b1, 0, 15);

    // Reset two cycles into a fetch, then the held request runs again.
    begin
      expT e;
      ackCycle  = 0;
      rdataBase = 32'h3333_0000;
      e.addr = 32'h600; e.we = 1'b0; e.wdata = '0; e.rdata = 32'h3333_0600;
      e.errBit = 1'b0; e.gap = 0; e.busyLen = 1;
      ifQ.push_back(e);
      ifAddr = 32'h600;
      ifReq  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkEq("busy_before_reset", {31'd0, memReq}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkEq("async_rst_mem_req", {31'd0, memReq}, 32'd0);
      checkEq("async_rst_mem_addr", memAddr, 32'd0);
      checkEq("async_rst_done_err", {29'd0, ifDone, dDone, errOut}, 32'd0);
      grantQ.delete();
      @(posedge clk);
      #1;
      checkEq("held_rst_mem_req", {31'd0, memReq}, 32'd0);
      checkEq("held_rst_if_done", {31'd0, ifDone}, 32'd0);
      ackCycle = 1;
      reset    = 1'b1;
      waitDone(1'b0);
      ifReq = 1'b0;
      @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    checkEq("if_queue_empty", ifQ.size(), 32'd0);
    checkEq("d_queue_empty", dQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
